// File: rtl/color_pkg.sv
// Shared colour types for the render domain.
package color_pkg;

    typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/render_ctrl_pkg.sv
// Types and constants for the per-frame render sequencer.
package render_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        RENDER,
        DONE
    } rc_state_t;

    localparam int GUARD_LEN = 2;
    localparam int GUARD_W   = 2;
    localparam int OVR_W     = 8;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fb_clear_scanner.sv
// Raster-scan fill engine: one pixel per cycle, x fastest, colour latched at start.
module fb_clear_scanner
    import color_pkg::*;
#(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int X_W       = $clog2(FB_WIDTH),
    parameter int Y_W       = $clog2(FB_HEIGHT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  rgb444_t        color,
    output logic           we,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output rgb444_t        data,
    output logic           done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(FB_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(FB_HEIGHT - 1);

    logic           active;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    rgb444_t        color_q;
    logic           last_x;
    logic           last_y;

    assign last_x = (x_cnt == X_LAST);
    assign last_y = (y_cnt == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            color_q <= '0;
        end else if (start) begin
            active  <= 1'b1;
            x_cnt   <= '0;
            y_cnt   <= '0;
            color_q <= color;
        end else if (active) begin
            // y is left at its last value once the final row completes
            if (last_x) begin
                x_cnt <= '0;
                if (last_y) begin
                    active <= 1'b0;
                end else begin
                    y_cnt <= y_cnt + 1'b1;
                end
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    assign we   = active;
    assign x    = x_cnt;
    assign y    = y_cnt;
    assign data = color_q;
    assign done = active && last_x && last_y;

endmodule

// File: rtl/render_frame_ctrl.sv
// Per-frame sequencer: clear back buffer, start feeder, merge raster writes, swap on frame pulse.
module render_frame_ctrl
    import color_pkg::*;
    import render_ctrl_pkg::*;
#(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int X_W       = $clog2(FB_WIDTH),
    parameter int Y_W       = $clog2(FB_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  rgb444_t          clear_color,
    output logic             feeder_begin,
    input  logic             feeder_busy,
    input  logic             raster_busy,
    input  logic             raster_valid,
    input  logic [X_W-1:0]   raster_x,
    input  logic [Y_W-1:0]   raster_y,
    input  rgb444_t          raster_color,
    output logic             raster_ready,
    output logic             fb_we,
    output logic [X_W-1:0]   fb_x,
    output logic [Y_W-1:0]   fb_y,
    output rgb444_t          fb_data,
    output logic             swap,
    output logic             busy,
    output logic [OVR_W-1:0] overrun_cnt,
    output rc_state_t        state
);

    localparam logic [X_W:0] X_LIM = (X_W + 1)'(FB_WIDTH);
    localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(FB_HEIGHT);

    rc_state_t        cur_state;
    rc_state_t        nxt_state;
    logic [GUARD_W-1:0] guard;
    logic             clr_start;
    logic             clr_we;
    logic [X_W-1:0]   clr_x;
    logic [Y_W-1:0]   clr_y;
    rgb444_t          clr_data;
    logic             clr_done;
    logic             raster_hs;
    logic             raster_in_range;
    logic             frame_busy;

    // Rasterizer handshake: a pixel transfers in any cycle where raster_valid
    // and raster_ready are both high; the rasterizer holds it stable until then.
    assign raster_hs       = raster_valid && raster_ready;
    assign raster_in_range = ({1'b0, raster_x} < X_LIM) && ({1'b0, raster_y} < Y_LIM);
    assign frame_busy      = (cur_state == CLEAR) || (cur_state == START) || (cur_state == RENDER);

    fb_clear_scanner #(
        .FB_WIDTH (FB_WIDTH),
        .FB_HEIGHT(FB_HEIGHT),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_clear (
        .clk  (clk),
        .rst  (rst),
        .start(clr_start),
        .color(clear_color),
        .we   (clr_we),
        .x    (clr_x),
        .y    (clr_y),
        .data (clr_data),
        .done (clr_done)
    );

    always_comb begin
        nxt_state = cur_state;
        clr_start = 1'b0;
        case (cur_state)
            IDLE: begin
                if (frame_start) begin
                    nxt_state = CLEAR;
                    clr_start = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_done) nxt_state = START;
            end
            START: nxt_state = RENDER;
            RENDER: begin
                // guard covers the delay before feeder_busy rises after feeder_begin
                if (guard == '0 && !feeder_busy && !raster_busy && !raster_valid) begin
                    nxt_state = DONE;
                end
            end
            DONE: begin
                if (frame_start) begin
                    nxt_state = CLEAR;
                    clr_start = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= IDLE;
            guard        <= '0;
            fb_we        <= 1'b0;
            fb_x         <= '0;
            fb_y         <= '0;
            fb_data      <= '0;
            swap         <= 1'b0;
            feeder_begin <= 1'b0;
            raster_ready <= 1'b0;
            busy         <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            cur_state    <= nxt_state;
            swap         <= (cur_state == DONE) && frame_start;
            feeder_begin <= (nxt_state == START);
            raster_ready <= (nxt_state == RENDER);
            busy         <= (nxt_state == CLEAR) || (nxt_state == START) || (nxt_state == RENDER);

            if (cur_state == START) begin
                guard <= GUARD_W'(GUARD_LEN);
            end else if (cur_state == RENDER && guard != '0) begin
                guard <= guard - 1'b1;
            end

            if (frame_start && frame_busy) begin
                overrun_cnt <= sat_inc(overrun_cnt);
            end

            if (cur_state == CLEAR && clr_we) begin
                fb_we   <= 1'b1;
                fb_x    <= clr_x;
                fb_y    <= clr_y;
                fb_data <= clr_data;
            end else if (raster_hs) begin
                fb_we   <= raster_in_range;
                fb_x    <= raster_x;
                fb_y    <= raster_y;
                fb_data <= raster_color;
            end else begin
                fb_we <= 1'b0;
            end
        end
    end

    assign state = cur_state;

endmodule
